// File: rtl/mux_rr_arbiter_pkg.sv
// mux_rr_arbiter shared definitions:
// FSM encoding, lane count and helpers.
package mux_rr_arbiter_pkg;

   localparam int N    = 8;
   localparam int SELW = 3;
   localparam int CNTW = 8;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   function automatic logic [N-1:0] onehot(
      input logic [SELW-1:0] idx
   );
      logic [N-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/grant/data bundle between the
// requesting lanes and the arbiter.
interface mux_rr_arbiter_if;
   import mux_rr_arbiter_pkg::*;

   logic [N-1:0]    req;
   logic            done;
   logic [N-1:0]    din;
   logic [N-1:0]    gnt;
   logic [SELW-1:0] sel;
   logic            valid;
   logic            dout;
   logic            timeout;

   modport master (
      output req,
      output done,
      output din,
      input  gnt,
      input  sel,
      input  valid,
      input  dout,
      input  timeout
   );

   modport slave (
      input  req,
      input  done,
      input  din,
      output gnt,
      output sel,
      output valid,
      output dout,
      output timeout
   );

endinterface

// File: rtl/mux_rr_arbiter_pick.sv
// Round-robin picker: first set request
// strictly after ptr, wrapping back to ptr.
module rr_pick
   import mux_rr_arbiter_pkg::*;
(
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   output logic            found,
   output logic [SELW-1:0] idx
);

   logic [SELW-1:0] cand;

   // scan ptr+1 .. ptr+8 (mod 8); ptr itself is last
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int i = 1; i <= N; i++) begin
         cand = ptr + SELW'(i);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of a shared 8:1 mux path
// with hold limit and registered grant/select.
module mux_rr_arbiter
   import mux_rr_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             rst,
   mux_rr_arbiter_if.slave  bus
);

   state_t          state_q;
   state_t          state_d;
   logic [N-1:0]    gnt_q;
   logic [N-1:0]    gnt_d;
   logic [SELW-1:0] sel_q;
   logic [SELW-1:0] sel_d;
   logic [SELW-1:0] ptr_q;
   logic [SELW-1:0] ptr_d;
   logic [CNTW-1:0] cnt_q;
   logic [CNTW-1:0] cnt_d;
   logic            to_q;
   logic            to_d;

   logic            found;
   logic [SELW-1:0] pick;
   logic            owner_req;
   logic            hold_hit;
   logic            release_c;
   logic            dout_c;

   rr_pick u_pick (
      .req   (bus.req),
      .ptr   (ptr_q),
      .found (found),
      .idx   (pick)
   );

   assign owner_req = bus.req[sel_q];
   assign hold_hit  = (cnt_q == CNTW'(MAX_HOLD - 1));
   assign release_c = bus.done | ~owner_req | hold_hit;

   // state and registered outputs; reset lands
   // ptr on the last lane so lane 0 wins first
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         ptr_q   <= SELW'(N - 1);
         cnt_q   <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         to_q    <= to_d;
      end
   end

   // next state: grant from IDLE, release from
   // BUSY; timeout only when the counter alone
   // forced the release
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      to_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            gnt_d = '0;
            sel_d = '0;
            cnt_d = '0;
            if (found) begin
               state_d = BUSY;
               gnt_d   = onehot(pick);
               sel_d   = pick;
               ptr_d   = pick;
            end
         end
         BUSY: begin
            if (release_c) begin
               state_d = IDLE;
               gnt_d   = '0;
               sel_d   = '0;
               cnt_d   = '0;
               to_d    = hold_hit & ~bus.done
                       & owner_req;
            end else if (cnt_q != CNTW'(MAX_HOLD)) begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
      endcase
   end

   // shared mux path, gated off without a grant
   always_comb begin
      dout_c = 1'b0;
      if (state_q == BUSY) begin
         unique case (sel_q)
            3'd0: dout_c = bus.din[0];
            3'd1: dout_c = bus.din[1];
            3'd2: dout_c = bus.din[2];
            3'd3: dout_c = bus.din[3];
            3'd4: dout_c = bus.din[4];
            3'd5: dout_c = bus.din[5];
            3'd6: dout_c = bus.din[6];
            3'd7: dout_c = bus.din[7];
         endcase
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.sel     = sel_q;
   assign bus.valid   = (state_q == BUSY);
   assign bus.dout    = dout_c;
   assign bus.timeout = to_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: vector table,
// corner sequences, random vs lane model.
module tb_mux_rr_arbiter;
   import mux_rr_arbiter_pkg::*;

   localparam int MH = 16;

   typedef struct {
      logic [7:0] req;
      logic       done;
      logic [7:0] din;
      logic [7:0] gnt;
      logic [2:0] sel;
      logic       valid;
      logic       dout;
      logic       to;
   } vec_t;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   int   m_owner;
   int   m_last;
   int   m_held;
   bit   m_to;

   vec_t tbl[17];

   mux_rr_arbiter_if bus ();

   mux_rr_arbiter #(
      .MAX_HOLD (MH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(
      input string      name,
      input logic [7:0] eg,
      input logic [2:0] es,
      input logic       ev,
      input logic       ed,
      input logic       et
   );
      n_vec++;
      if (bus.gnt !== eg || bus.sel !== es ||
          bus.valid !== ev || bus.dout !== ed ||
          bus.timeout !== et) begin
         n_err++;
         $display("FAIL %s t=%0t: got gnt=%h sel=%0d valid=%b dout=%b timeout=%b, need gnt=%h sel=%0d valid=%b dout=%b timeout=%b",
                  name, $time, bus.gnt, bus.sel,
                  bus.valid, bus.dout, bus.timeout,
                  eg, es, ev, ed, et);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_last  = 7;
      m_held  = 0;
      m_to    = 1'b0;
   endtask

   // one cycle of the lane-level model: who owns
   // the mux, and for how many cycles so far
   task automatic model_step(
      input logic [7:0] r,
      input logic       d
   );
      int  k;
      bit  full;
      if (m_owner < 0) begin
         m_to = 1'b0;
         for (int s = 1; s <= 8; s++) begin
            k = (m_last + s) % 8;
            if (r[k]) begin
               m_owner = k;
               m_last  = k;
               m_held  = 1;
               break;
            end
         end
      end else begin
         full = (m_held == MH);
         if (d || !r[m_owner] || full) begin
            m_to    = full && !d && r[m_owner];
            m_owner = -1;
         end else begin
            m_held++;
            m_to = 1'b0;
         end
      end
   endtask

   task automatic check_model(input string name);
      logic [7:0] eg;
      logic [2:0] es;
      logic       ed;
      eg = 8'd0;
      es = 3'd0;
      ed = 1'b0;
      if (m_owner >= 0) begin
         eg = 8'd1 << m_owner;
         es = 3'(m_owner);
         ed = bus.din[m_owner];
      end
      check(name, eg, es, (m_owner >= 0), ed, m_to);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      bus.req  = '0;
      bus.done = 1'b0;
      bus.din  = '0;
      tick();
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      n_vec    = 0;
      n_err    = 0;
      rst      = 1'b1;
      bus.req  = '0;
      bus.done = 1'b0;
      bus.din  = '0;
      model_reset();

      tbl[0]  = '{8'h05, 1'b0, 8'h00, 8'h01, 3'd0, 1'b1, 1'b0, 1'b0};
      tbl[1]  = '{8'h05, 1'b0, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1, 1'b0};
      tbl[2]  = '{8'h05, 1'b1, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{8'h05, 1'b0, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1, 1'b0};
      tbl[4]  = '{8'h05, 1'b0, 8'h00, 8'h04, 3'd2, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{8'h05, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{8'h05, 1'b0, 8'h00, 8'h01, 3'd0, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{8'h05, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{8'h05, 1'b0, 8'h00, 8'h04, 3'd2, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{8'h00, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{8'h08, 1'b0, 8'hAA, 8'h08, 3'd3, 1'b1, 1'b1, 1'b0};
      tbl[11] = '{8'h00, 1'b0, 8'hAA, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{8'h20, 1'b0, 8'hAA, 8'h20, 3'd5, 1'b1, 1'b1, 1'b0};
      tbl[13] = '{8'h00, 1'b0, 8'hAA, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
      tbl[14] = '{8'h40, 1'b0, 8'hAA, 8'h40, 3'd6, 1'b1, 1'b0, 1'b0};
      tbl[15] = '{8'h40, 1'b1, 8'hAA, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
      tbl[16] = '{8'h00, 1'b1, 8'hAA, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};

      // reset state and idle with no requests
      do_reset();
      check("reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      end

      // vector table
      do_reset();
      for (int i = 0; i < 17; i++) begin
         bus.req  = tbl[i].req;
         bus.done = tbl[i].done;
         bus.din  = tbl[i].din;
         tick();
         check($sformatf("vec%0d", i), tbl[i].gnt,
               tbl[i].sel, tbl[i].valid,
               tbl[i].dout, tbl[i].to);
      end

      // all lanes requesting: 0..7 then wrap to 0
      do_reset();
      for (int i = 0; i <= 8; i++) begin
         bus.req  = 8'hFF;
         bus.done = 1'b0;
         tick();
         check("rr_grant", 8'd1 << (i % 8),
               3'(i % 8), 1'b1, 1'b0, 1'b0);
         bus.done = 1'b1;
         tick();
         check("rr_bubble", 8'h00, 3'd0,
               1'b0, 1'b0, 1'b0);
      end

      // hold limit on a lone lane 4
      do_reset();
      bus.req  = 8'h10;
      bus.din  = 8'h10;
      bus.done = 1'b0;
      for (int j = 1; j <= MH; j++) begin
         tick();
         check("hold", 8'h10, 3'd4, 1'b1, 1'b1, 1'b0);
      end
      tick();
      check("timeout", 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
      tick();
      check("regrant", 8'h10, 3'd4, 1'b1, 1'b1, 1'b0);

      // done coinciding with the hold limit
      do_reset();
      bus.req  = 8'h02;
      bus.din  = 8'h00;
      for (int j = 1; j <= MH; j++) begin
         tick();
         check("hold1", 8'h02, 3'd1, 1'b1, 1'b0, 1'b0);
      end
      bus.done = 1'b1;
      tick();
      check("done_at_lim", 8'h00, 3'd0,
            1'b0, 1'b0, 1'b0);
      tick();
      check("idle_done", 8'h02, 3'd1, 1'b1, 1'b0, 1'b0);

      // async reset in the middle of a grant
      do_reset();
      bus.req = 8'h01;
      bus.din = 8'h01;
      tick();
      check("pre_rst", 8'h01, 3'd0, 1'b1, 1'b1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      model_reset();
      bus.req = 8'h00;
      tick();

      // randomized traffic against the lane model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0)
            bus.req = 8'($urandom_range(0, 255));
         bus.done = ($urandom_range(0, 19) == 0);
         bus.din  = 8'($urandom);
         model_step(bus.req, bus.done);
         tick();
         check_model("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
